// File: rtl/uio_bus_sched.sv
// uio_bus_sched
//   Round-robin owner of the shared uio pins. One requester at a time is
//   granted a bounded burst of byte beats. Every grant is framed by a LEAD
//   cycle (pins driven to 00) and a TAIL cycle (last beat held), followed by
//   TURNAROUND released cycles, so two sources never drive back to back.
//
// Ports
//   clk        single clock
//   rst_n      asynchronous active-low reset
//   ena        tile enable; low forces IDLE and suppresses acks
//   req_valid  [NREQ]   per-requester beat valid
//   req_last   [NREQ]   per-requester final-beat marker
//   req_data   [8*NREQ] requester i at [8i+7:8i]
//   req_ack    [NREQ]   beat accepted on the rising edge where high
//   gnt        [NREQ]   one-hot current owner, zero when unowned
//   uio_out    [8]      pin data
//   uio_oe     [8]      pin enable, 8'hFF or 8'h00
//   busy                high whenever the scheduler is not IDLE
//
// State table
//   state  | meaning
//   IDLE   | pins released, waiting for a valid requester
//   LEAD   | owner selected, pins driven to 00 for one cycle
//   XFER   | beats accepted from the owner, previous beat on pins
//   TAIL   | last accepted beat held on pins for one cycle
//   GAP    | pins released for TURNAROUND cycles before next grant

module uio_bus_sched #(
  parameter int NREQ       = 2,
  parameter int MAX_BURST  = 4,
  parameter int TURNAROUND = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ-1:0]   req_last,
  input  logic [8*NREQ-1:0] req_data,
  output logic [NREQ-1:0]   req_ack,
  output logic [NREQ-1:0]   gnt,
  output logic [7:0]        uio_out,
  output logic [7:0]        uio_oe,
  output logic              busy
);

  localparam int PW = (NREQ > 2) ? 2 : 1;

  typedef logic [PW-1:0] idx_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEAD,
    S_XFER,
    S_TAIL,
    S_GAP
  } state_t;

  localparam logic [3:0] BEAT_LAST = 4'(MAX_BURST - 1);
  // gap_cnt is a down-counter loaded on TAIL exit; GAP ends at terminal count 0.
  localparam logic [1:0] GAP_LOAD  = 2'((TURNAROUND > 0) ? TURNAROUND - 1 : 0);

  state_t      state, state_d;
  idx_t        gnt_q, gnt_d;
  idx_t        ptr, ptr_d;
  logic [7:0]  data_q, data_d;
  logic [3:0]  beat_cnt, beat_d;
  logic [1:0]  gap_cnt, gap_d;

  logic            any_valid;
  logic            found;
  idx_t            win;
  idx_t            cand;
  logic            sel_valid;
  logic            sel_last;
  logic [7:0]      sel_data;
  logic [NREQ-1:0] gnt_oh;

  function automatic idx_t wrap_add(input idx_t base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= NREQ) s = s - NREQ;
    return idx_t'(s);
  endfunction

  // Round-robin search starting at ptr.
  always_comb begin
    any_valid = |req_valid;
    found     = 1'b0;
    win       = ptr;
    cand      = ptr;
    for (int k = 0; k < NREQ; k++) begin
      cand = wrap_add(ptr, k);
      if (!found && req_valid[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  // Owner's request lines and one-hot grant vector.
  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_data  = 8'h00;
    gnt_oh    = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (gnt_q == idx_t'(k)) begin
        sel_valid = req_valid[k];
        sel_last  = req_last[k];
        sel_data  = req_data[8*k +: 8];
        gnt_oh[k] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      gnt_q    <= '0;
      ptr      <= '0;
      data_q   <= 8'h00;
      beat_cnt <= 4'd0;
      gap_cnt  <= 2'd0;
    end else begin
      state    <= state_d;
      gnt_q    <= gnt_d;
      ptr      <= ptr_d;
      data_q   <= data_d;
      beat_cnt <= beat_d;
      gap_cnt  <= gap_d;
    end
  end

  always_comb begin
    state_d = state;
    gnt_d   = gnt_q;
    ptr_d   = ptr;
    data_d  = data_q;
    beat_d  = beat_cnt;
    gap_d   = gap_cnt;

    if (!ena) begin
      // ptr survives a disable so fairness carries across enable toggles.
      state_d = S_IDLE;
      data_d  = 8'h00;
      beat_d  = 4'd0;
      gap_d   = 2'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (any_valid) begin
            gnt_d   = win;
            ptr_d   = wrap_add(win, 1);
            data_d  = 8'h00;
            beat_d  = 4'd0;
            state_d = S_LEAD;
          end
        end
        S_LEAD: state_d = S_XFER;
        S_XFER: begin
          if (sel_valid) begin
            data_d = sel_data;
            beat_d = beat_cnt + 4'd1;
            if (sel_last || beat_cnt == BEAT_LAST) state_d = S_TAIL;
          end else begin
            // A dropped valid mid-burst forfeits the rest of the grant.
            state_d = S_TAIL;
          end
        end
        S_TAIL: begin
          if (TURNAROUND > 0) begin
            state_d = S_GAP;
            gap_d   = GAP_LOAD;
          end else begin
            state_d = S_IDLE;
          end
        end
        S_GAP: begin
          if (gap_cnt == 2'd0) state_d = S_IDLE;
          else                 gap_d   = gap_cnt - 2'd1;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Pin-side outputs come from registers only; req_ack is the one
  // combinational path so a beat can be accepted in the cycle it appears.
  always_comb begin
    uio_oe  = 8'h00;
    uio_out = 8'h00;
    gnt     = '0;
    req_ack = '0;
    busy    = (state != S_IDLE);
    case (state)
      S_LEAD: begin
        uio_oe = 8'hFF;
        gnt    = gnt_oh;
      end
      S_XFER: begin
        uio_oe  = 8'hFF;
        uio_out = data_q;
        gnt     = gnt_oh;
        if (ena) req_ack = gnt_oh & {NREQ{sel_valid}};
      end
      S_TAIL: begin
        uio_oe  = 8'hFF;
        uio_out = data_q;
        gnt     = gnt_oh;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_uio_bus_sched.sv
// Scoreboard bench for uio_bus_sched (NREQ=2, MAX_BURST=4, TURNAROUND=1).
// Stimulus drives one cycle per call and queues the hand-derived outputs for
// that cycle; an independent monitor pops and compares on the falling edge.

module tb_uio_bus_sched;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ena;
  logic [1:0]  req_valid;
  logic [1:0]  req_last;
  logic [15:0] req_data;
  logic [1:0]  req_ack;
  logic [1:0]  gnt;
  logic [7:0]  uio_out;
  logic [7:0]  uio_oe;
  logic        busy;

  always #5 clk = ~clk;

  uio_bus_sched #(
    .NREQ(2),
    .MAX_BURST(4),
    .TURNAROUND(1)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .ena(ena),
    .req_valid(req_valid),
    .req_last(req_last),
    .req_data(req_data),
    .req_ack(req_ack),
    .gnt(gnt),
    .uio_out(uio_out),
    .uio_oe(uio_oe),
    .busy(busy)
  );

  typedef struct packed {
    logic [15:0] id;
    logic [7:0]  oe;
    logic [7:0]  dout;
    logic [1:0]  gnt;
    logic [1:0]  ack;
    logic        busy;
  } exp_t;

  exp_t exp_q[$];
  exp_t m_e;
  int   checks = 0;
  int   errors = 0;
  int   step_no = 0;
  logic rst_s = 1'b0;
  logic ena_s = 1'b0;
  logic [1:0] rr_oh;
  logic [7:0] rr_d;

  task automatic cyc(input logic [1:0] v, input logic [1:0] l,
                     input logic [7:0] d0, input logic [7:0] d1,
                     input logic e_oe, input logic [7:0] e_out,
                     input logic [1:0] e_gnt, input logic [1:0] e_ack,
                     input logic e_busy);
    exp_t e;
    @(posedge clk);
    #1;
    rst_n     = rst_s;
    ena       = ena_s;
    req_valid = v;
    req_last  = l;
    req_data  = {d1, d0};
    step_no++;
    e.id   = 16'(step_no);
    e.oe   = e_oe ? 8'hFF : 8'h00;
    e.dout = e_out;
    e.gnt  = e_gnt;
    e.ack  = e_ack;
    e.busy = e_busy;
    exp_q.push_back(e);
  endtask

  task automatic do_reset();
    rst_s = 1'b0;
    cyc(2'b00, 2'b00, 8'h00, 8'h00, 1'b0, 8'h00, 2'b00, 2'b00, 1'b0);
    rst_s = 1'b1;
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      m_e = exp_q.pop_front();
      checks++;
      if (uio_oe !== m_e.oe || uio_out !== m_e.dout || gnt !== m_e.gnt ||
          req_ack !== m_e.ack || busy !== m_e.busy) begin
        errors++;
        $display("FAIL step %0d: got oe=%h out=%h gnt=%b ack=%b busy=%b, need oe=%h out=%h gnt=%b ack=%b busy=%b",
                 m_e.id, uio_oe, uio_out, gnt, req_ack, busy,
                 m_e.oe, m_e.dout, m_e.gnt, m_e.ack, m_e.busy);
      end
    end
  end

  initial begin
    rst_n = 1'b0; ena = 1'b0; req_valid = '0; req_last = '0; req_data = '0;

    // Reset held with random inputs, then quiet release.
    rst_s = 1'b0; ena_s = 1'b1;
    for (int i = 0; i < 4; i++)
      cyc(2'($urandom), 2'($urandom), 8'($urandom), 8'($urandom),
          1'b0, 8'h00, 2'b00, 2'b00, 1'b0);
    rst_s = 1'b1;
    for (int i = 0; i < 3; i++)
      cyc(2'b00, 2'b00, 8'h00, 8'h00, 1'b0, 8'h00, 2'b00, 2'b00, 1'b0);

    // Single burst from requester 0: A1, A2, A3(last).
    cyc(2'b01, 2'b00, 8'hA1, 8'h00, 1'b0, 8'h00, 2'b00, 2'b00, 1'b0); // IDLE
    cyc(2'b01, 2'b00, 8'hA1, 8'h00, 1'b1, 8'h00, 2'b01, 2'b00, 1'b1); // LEAD
    cyc(2'b01, 2'b00, 8'hA1, 8'h00, 1'b1, 8'h00, 2'b01, 2'b01, 1'b1);
    cyc(2'b01, 2'b00, 8'hA2, 8'h00, 1'b1, 8'hA1, 2'b01, 2'b01, 1'b1);
    cyc(2'b01, 2'b01, 8'hA3, 8'h00, 1'b1, 8'hA2, 2'b01, 2'b01, 1'b1);
    cyc(2'b00, 2'b00, 8'h00, 8'h00, 1'b1, 8'hA3, 2'b01, 2'b00, 1'b1); // TAIL
    cyc(2'b00, 2'b00, 8'h00, 8'h00, 1'b0, 8'h00, 2'b00, 2'b00, 1'b1); // GAP
    cyc(2'b00, 2'b00, 8'h00, 8'h00, 1'b0, 8'h00, 2'b00, 2'b00, 1'b0); // IDLE

    // Burst cap: requester 1 streams 10..15 with no last.
    do_reset();
    cyc(2'b10, 2'b00, 8'h00, 8'h10, 1'b0, 8'h00, 2'b00, 2'b00, 1'b0);
    cyc(2'b10, 2'b00, 8'h00, 8'h10, 1'b1, 8'h00, 2'b10, 2'b00, 1'b1);
    cyc(2'b10, 2'b00, 8'h00, 8'h10, 1'b1, 8'h00, 2'b10, 2'b10, 1'b1);
    cyc(2'b10, 2'b00, 8'h00, 8'h11, 1'b1, 8'h10, 2'b10, 2'b10, 1'b1);
    cyc(2'b10, 2'b00, 8'h00, 8'h12, 1'b1, 8'h11, 2'b10, 2'b10, 1'b1);
    cyc(2'b10, 2'b00, 8'h00, 8'h13, 1'b1, 8'h12, 2'b10, 2'b10, 1'b1);
    cyc(2'b10, 2'b00, 8'h00, 8'h14, 1'b1, 8'h13, 2'b10, 2'b00, 1'b1); // TAIL
    cyc(2'b10, 2'b00, 8'h00, 8'h14, 1'b0, 8'h00, 2'b00, 2'b00, 1'b1); // GAP
    cyc(2'b10, 2'b00, 8'h00, 8'h14, 1'b0, 8'h00, 2'b00, 2'b00, 1'b0); // IDLE
    cyc(2'b10, 2'b00, 8'h00, 8'h14, 1'b1, 8'h00, 2'b10, 2'b00, 1'b1); // LEAD
    cyc(2'b10, 2'b00, 8'h00, 8'h14, 1'b1, 8'h00, 2'b10, 2'b10, 1'b1);
    cyc(2'b10, 2'b00, 8'h00, 8'h15, 1'b1, 8'h14, 2'b10, 2'b10, 1'b1);
    cyc(2'b00, 2'b00, 8'h00, 8'h00, 1'b1, 8'h15, 2'b10, 2'b00, 1'b1); // drop
    cyc(2'b00, 2'b00, 8'h00, 8'h00, 1'b1, 8'h15, 2'b10, 2'b00, 1'b1); // TAIL
    cyc(2'b00, 2'b00, 8'h00, 8'h00, 1'b0, 8'h00, 2'b00, 2'b00, 1'b1);
    cyc(2'b00, 2'b00, 8'h00, 8'h00, 1'b0, 8'h00, 2'b00, 2'b00, 1'b0);

    // Round-robin with single-beat bursts: owners 0,1,0,1.
    do_reset();
    for (int r = 0; r < 4; r++) begin
      rr_oh = (r % 2 == 0) ? 2'b01 : 2'b10;
      rr_d  = (r % 2 == 0) ? 8'hC0 : 8'hC1;
      cyc(2'b11, 2'b11, 8'hC0, 8'hC1, 1'b0, 8'h00, 2'b00, 2'b00, 1'b0);
      cyc(2'b11, 2'b11, 8'hC0, 8'hC1, 1'b1, 8'h00, rr_oh, 2'b00, 1'b1);
      cyc(2'b11, 2'b11, 8'hC0, 8'hC1, 1'b1, 8'h00, rr_oh, rr_oh, 1'b1);
      cyc(2'b11, 2'b11, 8'hC0, 8'hC1, 1'b1, rr_d,  rr_oh, 2'b00, 1'b1);
      cyc(2'b11, 2'b11, 8'hC0, 8'hC1, 1'b0, 8'h00, 2'b00, 2'b00, 1'b1);
    end
    cyc(2'b00, 2'b00, 8'h00, 8'h00, 1'b0, 8'h00, 2'b00, 2'b00, 1'b0);

    // ena drop during requester 0's second XFER cycle.
    do_reset();
    cyc(2'b11, 2'b00, 8'h21, 8'h31, 1'b0, 8'h00, 2'b00, 2'b00, 1'b0);
    cyc(2'b11, 2'b00, 8'h21, 8'h31, 1'b1, 8'h00, 2'b01, 2'b00, 1'b1);
    cyc(2'b11, 2'b00, 8'h21, 8'h31, 1'b1, 8'h00, 2'b01, 2'b01, 1'b1);
    ena_s = 1'b0;
    cyc(2'b11, 2'b00, 8'h22, 8'h31, 1'b1, 8'h21, 2'b01, 2'b00, 1'b1);
    cyc(2'b11, 2'b00, 8'h22, 8'h31, 1'b0, 8'h00, 2'b00, 2'b00, 1'b0);
    ena_s = 1'b1;
    cyc(2'b11, 2'b10, 8'h22, 8'h31, 1'b0, 8'h00, 2'b00, 2'b00, 1'b0);
    cyc(2'b11, 2'b10, 8'h22, 8'h31, 1'b1, 8'h00, 2'b10, 2'b00, 1'b1);
    cyc(2'b11, 2'b10, 8'h22, 8'h31, 1'b1, 8'h00, 2'b10, 2'b10, 1'b1);
    cyc(2'b00, 2'b00, 8'h00, 8'h00, 1'b1, 8'h31, 2'b10, 2'b00, 1'b1);
    cyc(2'b00, 2'b00, 8'h00, 8'h00, 1'b0, 8'h00, 2'b00, 2'b00, 1'b1);
    cyc(2'b00, 2'b00, 8'h00, 8'h00, 1'b0, 8'h00, 2'b00, 2'b00, 1'b0);

    // Valid drop after one beat.
    do_reset();
    cyc(2'b01, 2'b00, 8'h55, 8'h00, 1'b0, 8'h00, 2'b00, 2'b00, 1'b0);
    cyc(2'b01, 2'b00, 8'h55, 8'h00, 1'b1, 8'h00, 2'b01, 2'b00, 1'b1);
    cyc(2'b01, 2'b00, 8'h55, 8'h00, 1'b1, 8'h00, 2'b01, 2'b01, 1'b1);
    cyc(2'b00, 2'b00, 8'h00, 8'h00, 1'b1, 8'h55, 2'b01, 2'b00, 1'b1);
    cyc(2'b00, 2'b00, 8'h00, 8'h00, 1'b1, 8'h55, 2'b01, 2'b00, 1'b1);
    cyc(2'b00, 2'b00, 8'h00, 8'h00, 1'b0, 8'h00, 2'b00, 2'b00, 1'b1);
    cyc(2'b00, 2'b00, 8'h00, 8'h00, 1'b0, 8'h00, 2'b00, 2'b00, 1'b0);

    // Owner drops valid during LEAD: empty XFER, TAIL shows 00.
    do_reset();
    cyc(2'b01, 2'b00, 8'h77, 8'h00, 1'b0, 8'h00, 2'b00, 2'b00, 1'b0);
    cyc(2'b00, 2'b00, 8'h77, 8'h00, 1'b1, 8'h00, 2'b01, 2'b00, 1'b1);
    cyc(2'b00, 2'b00, 8'h77, 8'h00, 1'b1, 8'h00, 2'b01, 2'b00, 1'b1);
    cyc(2'b00, 2'b00, 8'h00, 8'h00, 1'b1, 8'h00, 2'b01, 2'b00, 1'b1);
    cyc(2'b00, 2'b00, 8'h00, 8'h00, 1'b0, 8'h00, 2'b00, 2'b00, 1'b1);
    cyc(2'b00, 2'b00, 8'h00, 8'h00, 1'b0, 8'h00, 2'b00, 2'b00, 1'b0);

    @(posedge clk);
    @(posedge clk);
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expected entries left, need 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uio_bus_sched.md
# uio_bus_sched

Round-robin scheduler that shares the eight bidirectional `uio` pins of the tile top between NREQ internal byte-stream requesters. It grants the bus to one requester at a time for a bounded burst, owns `uio_oe`/`uio_out`, and inserts a lead cycle and a turnaround gap so that no two sources ever drive the pins back to back. It sits directly between the user-project top and its data producers. Tile-level enable gating is handled here through `ena`.

## Interface

Parameters:
- NREQ, 2: number of requesters, legal range 2..4.
- MAX_BURST, 4: maximum beats per grant, legal range 1..16.
- TURNAROUND, 1: released-bus cycles after each burst, legal range 0..3.

Ports:
- clk  in  1  single clock.
- rst_n  in  1  asynchronous, active-low reset.
- ena  in  1  tile enable; low forces IDLE.
- req_valid  in  NREQ  per-requester data valid.
- req_last  in  NREQ  marks a requester's final beat.
- req_data  in  8*NREQ  requester i occupies [8i+7:8i].
- req_ack  out  NREQ  beat accepted on the rising edge where high.
- gnt  out  NREQ  one-hot current owner; zero when no owner.
- uio_out  out  8  pin output data.
- uio_oe  out  8  pin output enable, 8'hFF or 8'h00 only.
- busy  out  1  high whenever state != IDLE.

## Operation

- Internal registers: state, gnt_q (index), ptr (round-robin), data_q[7:0], beat_cnt[3:0], gap_cnt[1:0].
- IDLE:
  - Outputs: oe=00, uio_out=00, gnt=0, ack=0.
  - If ena=1 and any valid: winner is the first valid requester searching ptr, ptr+1, … mod NREQ.
  - Register the winner, set ptr <= winner+1 mod NREQ, clear data_q and beat_cnt, go to LEAD.
- LEAD (1 cycle):
  - Outputs: gnt=winner, oe=FF, uio_out=00, ack=0.
  - Next state is XFER.
- XFER:
  - Outputs: gnt=winner, oe=FF, uio_out=data_q.
  - req_ack[g] = req_valid[g], combinational. All other ack bits are 0.
  - On an accepted beat: data_q <= req_data[g] and beat_cnt++.
  - Go to TAIL if the accepted beat has req_last=1, or if beat_cnt == MAX_BURST-1.
  - If req_valid[g]=0: accept nothing and go to TAIL (a mid-burst drop ends the grant).
- TAIL (1 cycle):
  - Outputs: gnt=winner, oe=FF, uio_out=data_q (the last accepted beat), ack=0.
  - Next state is GAP if TURNAROUND>0, else IDLE.
- GAP:
  - Outputs: oe=00, uio_out=00, gnt=0, ack=0.
  - Stays TURNAROUND cycles, counted by gap_cnt, then goes to IDLE.
- ena=0 in any state: at the next edge go to IDLE and clear data_q, beat_cnt and gap_cnt. ptr is kept. No ack is issued while ena=0.
- Reset: state=IDLE, ptr=0, all registers 0. Every output is 0, including uio_oe=00.
- All outputs are decoded from registers only, except req_ack (combinational from req_valid in XFER).

## Timing

- req_valid first high in IDLE cycle t:
  - LEAD in t+1.
  - First ack in t+2.
  - That beat appears on uio_out in t+3.
- A beat accepted at the end of cycle n is visible on the pins in cycle n+1. The last beat is visible in TAIL.
- A burst of B beats with no stall holds oe=FF for B+2 cycles (LEAD + B XFER + TAIL), then oe=00 for TURNAROUND cycles.
- Minimum spacing from one grant's TAIL to the next grant's LEAD is TURNAROUND+1 cycles (GAP + IDLE).
- When MAX_BURST=1, the first accepted beat always ends the burst.
- Valid and last both high on the MAX_BURST-th beat: a single TAIL. No double-count, no extra beat.
- The winner's own valid going low in LEAD has no effect. XFER then goes straight to TAIL, with uio_out=00 in TAIL.
- Valid changes of non-granted requesters are ignored until IDLE.

## Test plan

- Reset: hold rst_n=0 with random inputs → uio_oe=00, uio_out=00, gnt=0, req_ack=0, busy=0. After release with no valid, the block stays IDLE.
- Single burst, NREQ=2, MAX_BURST=4, TURNAROUND=1: requester 0 sends A1, A2, A3 with last on A3.
  - uio_out sequence = 00 (LEAD), 00, A1, A2, A3 (TAIL), with oe=FF for those 5 cycles.
  - Then 1 GAP cycle with oe=00, then busy=0.
  - ack high exactly 3 cycles.
- Burst cap: requester 1 streams 0x10..0x15 with no last.
  - Beats 0x10..0x13 are accepted, then TAIL shows 13, GAP, IDLE.
  - Re-grant to requester 1 (the only one valid), which sends 0x14 and 0x15.
- Round-robin: both requesters valid continuously with single-beat bursts (last=1).
  - gnt sequence = 01, 10, 01, 10.
  - Each LEAD is separated from the previous TAIL by 2 cycles.
- ena drop: ena=0 during the second XFER cycle of requester 0.
  - Next cycle: oe=00, gnt=0, busy=0, no further ack.
  - ena=1 again with both requesters valid → requester 1 is granted first.
- Valid drop: requester 0 sends 0x55 then drops valid without last → TAIL shows 55, then GAP; total acks = 1.
